wb_port_sched: RTL
==================

WB_PORT_SCHED -- requirements
Module: wb_port_sched

Interface
Parameters:
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 3: consecutive lost arbitrations after which the ALU requester is promoted to top priority.

Ports:
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port alu_req  input  1  ALU result ready for writeback; held high until alu_gnt.
REQ-005 The block SHALL have port alu_rd  input  1  ALU destination field: 1 = rd [15:11], 0 = rt.
REQ-006 The block SHALL have port mem_req  input  1  load data ready in MDR (destination rt); held until mem_gnt.
REQ-007 The block SHALL have port link_req  input  1  JAL/JALR link write of PC+4 to $ra (31); held until link_gnt.
REQ-008 The block SHALL have port flush  input  1  abort a not-yet-committed writeback.
REQ-009 The block SHALL have ports alu_gnt, mem_gnt, link_gnt  output  1 each  one-cycle grant, asserted in the write cycle.
REQ-010 The block SHALL have port reg_dst_sel  output  2  destination-mux select: 00 rt, 01 rd, 11 $ra; 10 never driven.
REQ-011 The block SHALL have port wb_data_sel  output  2  data-mux select: 00 ALUOut, 01 MDR, 10 PC+4; 11 never driven.
REQ-012 The block SHALL have port reg_write  output  1  register-bank write enable.
REQ-013 The block SHALL have port wb_busy  output  1  high whenever state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SETUP, WRITE.
REQ-015 Arbitration SHALL run in IDLE and in WRITE; winner = ALU if starve count equals STARVE_LIMIT and alu_req is high, else fixed priority mem > link > alu.
REQ-016 In WRITE, the requester currently being granted SHALL be masked out of arbitration.
REQ-017 IDLE -> SETUP SHALL occur on the edge following any unmasked request with flush low; the winner is registered at that edge.
REQ-018 In SETUP, reg_dst_sel and wb_data_sel SHALL carry the winner's values (alu: 00/01 per alu_rd with data 00; mem: 00/01; link: 11/10), and reg_write SHALL be 0.
REQ-019 SETUP -> WRITE SHALL occur on the next edge when flush is low; SETUP -> IDLE when flush is high, with no write and no grant.
REQ-020 In WRITE, reg_write SHALL be 1, the winner's gnt SHALL be 1, and the selects SHALL be held unchanged from SETUP.
REQ-021 WRITE SHALL go to SETUP when a masked arbitration finds a winner, else to IDLE; flush SHALL NOT cancel a WRITE already in progress.
REQ-022 Sustained throughput SHALL be one register write per 2 cycles; latency from req rising in IDLE to gnt SHALL be 2 cycles.
REQ-023 In IDLE, the selects SHALL hold their last driven values; reg_write and all gnt SHALL be 0.
REQ-024 The starve counter SHALL increment, saturating at STARVE_LIMIT, on each arbitration that selects a winner while alu_req is high and ALU loses.
REQ-025 The starve counter SHALL clear when alu_gnt is asserted or when alu_req is low at an arbitration.
REQ-026 At most one gnt SHALL be high per cycle, and a gnt SHALL be high only together with reg_write.
REQ-027 flush high in IDLE SHALL block the start of a transaction; the starve counter is unchanged by flush.

Reset
REQ-028 While reset is low: state = IDLE, reg_dst_sel = 00, wb_data_sel = 00, reg_write = 0, all gnt = 0, wb_busy = 0, starve counter = 0.
REQ-029 Reset asserted during SETUP or WRITE SHALL abort immediately with no further reg_write.
REQ-030 After reset release, the first transaction SHALL start on the first clk edge that sees a request.

Verification
REQ-031 Single ALU request, alu_req=1 with alu_rd=1 at cycle 0 -> SETUP at cycle 1 with sel 01/00; cycle 2 reg_write=1, alu_gnt=1; IDLE at cycle 3.
REQ-032 All three requests held simultaneously -> grants in order mem (cycle 2), link (cycle 4, sel 11/10), alu (cycle 6); wb_busy high for cycles 1-6.
REQ-033 Starvation, alu_req held with mem_req/link_req re-raised continuously and STARVE_LIMIT=3 -> alu_gnt on the 4th write.
REQ-034 flush=1 during SETUP for a mem_req -> no reg_write, no mem_gnt, IDLE next cycle; mem_req still high -> retried and granted 2 cycles later.
REQ-035 reset driven low asynchronously mid-WRITE -> reg_write and gnt drop without a clock edge; all outputs at REQ-028 values.

Source files
------------

// File: rtl/wb_port_sched_if.sv
// Writeback request/grant bundle between the requesters and the writeback-port scheduler.
interface wb_port_sched_if;
   logic       alu_req;
   logic       alu_rd;
   logic       mem_req;
   logic       link_req;
   logic       flush;
   logic       alu_gnt;
   logic       mem_gnt;
   logic       link_gnt;
   logic [1:0] reg_dst_sel;
   logic [1:0] wb_data_sel;
   logic       reg_write;
   logic       wb_busy;

   modport master (
      output alu_req, alu_rd, mem_req, link_req, flush,
      input  alu_gnt, mem_gnt, link_gnt, reg_dst_sel, wb_data_sel, reg_write, wb_busy
   );

   modport slave (
      input  alu_req, alu_rd, mem_req, link_req, flush,
      output alu_gnt, mem_gnt, link_gnt, reg_dst_sel, wb_data_sel, reg_write, wb_busy
   );
endinterface

// File: rtl/wb_port_sched.sv
// Register-file writeback port scheduler: arbitrates ALU, load and link writes, one write per two cycles,
// with an anti-starvation promotion for the ALU requester.
module wb_port_sched #(
   parameter int STARVE_LIMIT = 3
) (
   input logic            clk,
   input logic            reset,
   wb_port_sched_if.slave wb
);

   localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, SETUP, WRITE} state_e;
   typedef enum logic [1:0] {SRC_ALU, SRC_MEM, SRC_LINK} src_e;

   state_e        state_q, state_d;
   src_e          win_q, win_d;
   src_e          arb_win;
   logic [1:0]    dst_q, dst_d;
   logic [1:0]    data_q, data_d;
   logic [CW-1:0] starve_q, starve_d;
   logic          alu_m, mem_m, link_m;
   logic          arb_en, found, writing;

   // The requester being written this cycle is masked so it cannot win twice for one request.
   always_comb begin
      alu_m   = wb.alu_req  && !(state_q == WRITE && win_q == SRC_ALU);
      mem_m   = wb.mem_req  && !(state_q == WRITE && win_q == SRC_MEM);
      link_m  = wb.link_req && !(state_q == WRITE && win_q == SRC_LINK);
      arb_en  = (state_q == WRITE) || (state_q == IDLE && !wb.flush);
      found   = arb_en && (alu_m || mem_m || link_m);
      arb_win = SRC_ALU;
      if (alu_m && starve_q == LIMIT) arb_win = SRC_ALU;
      else if (mem_m)                 arb_win = SRC_MEM;
      else if (link_m)                arb_win = SRC_LINK;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (found) state_d = SETUP;
         SETUP:   state_d = wb.flush ? IDLE : WRITE;
         WRITE:   state_d = found ? SETUP : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Mux selects are captured at arbitration so they are stable through SETUP and WRITE.
   always_comb begin
      win_d    = win_q;
      dst_d    = dst_q;
      data_d   = data_q;
      starve_d = starve_q;
      if (found) begin
         win_d = arb_win;
         unique case (arb_win)
            SRC_MEM:  begin dst_d = 2'b00; data_d = 2'b01; end
            SRC_LINK: begin dst_d = 2'b11; data_d = 2'b10; end
            default:  begin dst_d = {1'b0, wb.alu_rd}; data_d = 2'b00; end
         endcase
      end
      if (state_q == WRITE && win_q == SRC_ALU)                         starve_d = '0;
      else if (arb_en && !wb.alu_req)                                   starve_d = '0;
      else if (found && arb_win != SRC_ALU && starve_q != LIMIT)        starve_d = starve_q + CW'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         win_q    <= SRC_ALU;
         dst_q    <= 2'b00;
         data_q   <= 2'b00;
         starve_q <= '0;
      end else begin
         win_q    <= win_d;
         dst_q    <= dst_d;
         data_q   <= data_d;
         starve_q <= starve_d;
      end
   end

   always_comb begin
      writing        = (state_q == WRITE);
      wb.reg_write   = writing;
      wb.alu_gnt     = writing && win_q == SRC_ALU;
      wb.mem_gnt     = writing && win_q == SRC_MEM;
      wb.link_gnt    = writing && win_q == SRC_LINK;
      wb.reg_dst_sel = dst_q;
      wb.wb_data_sel = data_q;
      wb.wb_busy     = (state_q != IDLE);
   end

endmodule
